mem_stage: RTL
==============

Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM pipeline register outputs and executes LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-wide, 1-cycle-latency RAM port, one byte per cycle.
- Holds the pipeline through stall_req while an access is in flight.
- Presents write-back data to the MEM/WB register.

Parameters:
ADDR_WIDTH, 32, width of mem_a (low bits of the effective address)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
mem_wd_i  input  5  destination register from EX/MEM
mem_wreg_i  input  1  write enable from EX/MEM
mem_wdata_i  input  32  ALU result from EX/MEM
mem_addr_i  input  32  effective address from EX/MEM
mem_store_data_i  input  32  store data (rs2) from EX/MEM
mem_inst_i  input  32  instruction word from EX/MEM
pipe_hold  input  1  external stall of stage 4 (MEM/WB will not capture this cycle)
mem_din  input  8  RAM read data (1-cycle latency)
mem_dout  output  8  RAM write data
mem_a  output  ADDR_WIDTH  RAM byte address
mem_wr  output  1  RAM write strobe (1=write)
stall_req  output  1  request stall of stages 0-3
wb_wd  output  5  destination register to MEM/WB
wb_wreg  output  1  write enable to MEM/WB
wb_wdata  output  32  write-back data to MEM/WB

Behaviour:
- Decode:
  - opcode = inst[6:0], funct3 = inst[14:12].
  - LOAD = 7'b0000011, STORE = 7'b0100011.
  - Byte count n: funct3[1:0]: 00→1, 01→2, 10→4.
  - All other opcodes are pass-through. Reserved funct3 is treated as pass-through.
- FSM states and registers:
  - States: IDLE, LOAD, STORE, DONE.
  - Registers: 2-bit byte counter cnt, 32-bit load buffer buf.
- IDLE:
  - Pass-through instruction: wb_* = mem_*_i combinationally, stall_req=0, mem_wr=0, mem_a=0.
  - Load: issue mem_a=addr+0, mem_wr=0, stall_req=1; next state LOAD, cnt=1.
  - Store: mem_a=addr+0, mem_dout=store_data[7:0], mem_wr=1, stall_req=1.
    - If n=1, next state DONE.
    - Otherwise next state STORE, cnt=1.
- LOAD:
  - Capture mem_din into buf byte (cnt-1).
  - If cnt<n: issue mem_a=addr+cnt, cnt++.
  - Else: next state DONE.
  - stall_req=1 throughout; mem_wr=0.
- STORE:
  - mem_a=addr+cnt, mem_dout=store_data byte cnt, mem_wr=1, stall_req=1.
  - If cnt==n-1, next state DONE; else cnt++.
- DONE:
  - stall_req=0, mem_wr=0.
  - wb_wd=mem_wd_i, wb_wreg=mem_wreg_i.
  - Load: wb_wdata = buf[8n-1:0], sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
  - Store: wb_wdata=mem_wdata_i.
  - Next state IDLE unless pipe_hold=1; while held, stay in DONE with the same result and no RAM activity.
- Stall timing:
  - While stall_req=1 (states LOAD/STORE, or IDLE issuing a memory op), wb_wreg=0 and wb_wd=0.
- Latency:
  - LW: stall_req high 5 cycles, result on cycle 6. LB: 2 cycles, result on cycle 3.
  - SW: 4 write cycles + DONE. SB: 1 write cycle + DONE.
- Address arithmetic:
  - addr+k is computed modulo 2^32, then truncated to ADDR_WIDTH.
  - Unaligned accesses are legal: byte-serial access, no trap.
  - 0xFFFFFFFF+1 wraps to 0.
- Inputs are stable during LOAD/STORE: EX/MEM is held by stall_req. In those states, changes to mem_inst_i are ignored.
- Reset: rst=1 at any edge forces IDLE, cnt=0, buf=0.
  - During rst, all outputs read 0: mem_wr=0, stall_req=0, mem_a=0, mem_dout=0, wb_*=0.
  - Reset mid-store aborts after the bytes already written; no further writes occur.

Optional Feature:
MEM_FWD_EN:
- When defined, adds outputs fwd_we (1), fwd_wd (5), fwd_wdata (32) for ID-stage forwarding.
- fwd_we = wb_wreg & ~stall_req; fwd_wd/fwd_wdata mirror wb_wd/wb_wdata; all are 0 in reset.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- ADD pass-through, wd=5, wreg=1, wdata=0x1234 -> same cycle wb_wd=5, wb_wreg=1, wb_wdata=0x1234, stall_req=0, mem_wr=0.
- LW from addr 0x100, RAM bytes 0x78,0x56,0x34,0x12 -> mem_a 0x100..0x103 on consecutive cycles, stall_req high 5 cycles, then wb_wdata=0x12345678.
- LB/LBU at 0x203 with byte 0x80 -> LB gives wb_wdata=0xFFFFFF80; LBU gives 0x00000080; stall_req high 2 cycles each.
- SH at unaligned 0x001FF, data 0xAABBCCDD -> writes 0xDD@0x1FF then 0xCC@0x200 with mem_wr=1, then DONE with wb_wreg=0, stall_req=0.
- LW completes with pipe_hold=1 for 3 cycles -> DONE held; wb_wdata stable; no mem_a/mem_wr activity; IDLE after pipe_hold drops.
- rst asserted during SW after byte 1 -> next cycle mem_wr=0, stall_req=0, state IDLE; following LB executes normally.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : RV32I MEM stage. Byte-serial LB/LH/LW/LBU/LHU/SB/SH/SW over a
//            byte-wide RAM port with 1-cycle read latency. Define MEM_FWD_EN
//            to add the ID-stage forwarding outputs fwd_we/fwd_wd/fwd_wdata.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            mem_wd_i,
    input  logic                  mem_wreg_i,
    input  logic [31:0]           mem_wdata_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_store_data_i,
    input  logic [31:0]           mem_inst_i,
    input  logic                  pipe_hold,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic                  stall_req,
    output logic [4:0]            wb_wd,
    output logic                  wb_wreg,
    output logic [31:0]           wb_wdata
`ifdef MEM_FWD_EN
    ,
    output logic                  fwd_we,
    output logic [4:0]            fwd_wd,
    output logic [31:0]           fwd_wdata
`endif
);

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [2:0]  f3_q, f3_d;
    logic        is_ld_q, is_ld_d;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic        w_is_load;
    logic        w_is_store;
    logic [2:0]  w_n_new;
    logic [2:0]  w_n_q;
    logic [2:0]  w_cnt_ext;
    logic [1:0]  w_idx;
    logic [31:0] w_ld_ext;
    logic [31:0] w_sum;
    logic        w_acc;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_stall;
    logic [7:0]  w_dout;
    logic        w_wreg;
    logic [4:0]  w_wd;
    logic [31:0] w_wdata;
    logic        w_unused;

    function automatic logic [2:0] f_nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   f_nbytes = 3'd1;
            2'b01:   f_nbytes = 3'd2;
            default: f_nbytes = 3'd4;
        endcase
    endfunction

    assign w_opcode   = mem_inst_i[6:0];
    assign w_f3       = mem_inst_i[14:12];
    assign w_unused   = ^{mem_inst_i[31:15], mem_inst_i[11:7]};
    // Valid loads: 000,001,010,100,101; valid stores: 000,001,010
    assign w_is_load  = (w_opcode == c_op_load) && (w_f3[1:0] != 2'b11)
                        && !(w_f3[2] && w_f3[1]);
    assign w_is_store = (w_opcode == c_op_store) && !w_f3[2] && (w_f3[1:0] != 2'b11);
    assign w_n_new    = f_nbytes(w_f3[1:0]);
    assign w_n_q      = f_nbytes(f3_q[1:0]);

    // The 2-bit counter wraps to 0 after issuing byte 3 of a word; treat 0 as 4
    assign w_cnt_ext  = {cnt_q == 2'd0, cnt_q};
    assign w_idx      = cnt_q - 2'd1;

    always_comb begin
        case (f3_q[1:0])
            2'b00:   w_ld_ext = {{24{buf_q[7]  & ~f3_q[2]}}, buf_q[7:0]};
            2'b01:   w_ld_ext = {{16{buf_q[15] & ~f3_q[2]}}, buf_q[15:0]};
            default: w_ld_ext = buf_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        f3_d    = f3_q;
        is_ld_d = is_ld_q;
        w_acc   = 1'b0;
        w_off   = 2'd0;
        w_wr    = 1'b0;
        w_stall = 1'b0;
        w_dout  = 8'h00;
        w_wreg  = 1'b0;
        w_wd    = 5'd0;
        w_wdata = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (w_is_load) begin
                    w_acc   = 1'b1;
                    w_stall = 1'b1;
                    f3_d    = w_f3;
                    is_ld_d = 1'b1;
                    cnt_d   = 2'd1;
                    state_d = S_LOAD;
                end else if (w_is_store) begin
                    w_acc   = 1'b1;
                    w_wr    = 1'b1;
                    w_stall = 1'b1;
                    w_dout  = mem_store_data_i[7:0];
                    f3_d    = w_f3;
                    is_ld_d = 1'b0;
                    if (w_n_new == 3'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = 2'd1;
                        state_d = S_STORE;
                    end
                end else begin
                    w_wreg  = mem_wreg_i;
                    w_wd    = mem_wd_i;
                    w_wdata = mem_wdata_i;
                end
            end
            S_LOAD: begin
                w_stall = 1'b1;
                buf_d[{w_idx, 3'b000} +: 8] = mem_din;
                if (w_cnt_ext < w_n_q) begin
                    w_acc = 1'b1;
                    w_off = cnt_q;
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_STORE: begin
                w_acc   = 1'b1;
                w_off   = cnt_q;
                w_wr    = 1'b1;
                w_stall = 1'b1;
                w_dout  = mem_store_data_i[{cnt_q, 3'b000} +: 8];
                if ({1'b0, cnt_q} == (w_n_q - 3'd1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                w_wreg  = mem_wreg_i;
                w_wd    = mem_wd_i;
                w_wdata = is_ld_q ? w_ld_ext : mem_wdata_i;
                if (!pipe_hold) begin
                    cnt_d   = 2'd0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 32'h0;
            f3_q    <= 3'd0;
            is_ld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            f3_q    <= f3_d;
            is_ld_q <= is_ld_d;
        end
    end

    // Outputs are forced quiet while reset is held, even for pass-through
    assign w_sum     = mem_addr_i + {30'd0, w_off};
    assign mem_a     = (w_acc && !rst) ? w_sum[ADDR_WIDTH-1:0] : '0;
    assign mem_wr    = w_wr & ~rst;
    assign mem_dout  = rst ? 8'h00 : w_dout;
    assign stall_req = w_stall & ~rst;
    assign wb_wreg   = w_wreg & ~rst;
    assign wb_wd     = rst ? 5'd0 : w_wd;
    assign wb_wdata  = rst ? 32'h0 : w_wdata;

`ifdef MEM_FWD_EN
    assign fwd_we    = wb_wreg & ~stall_req;
    assign fwd_wd    = wb_wd;
    assign fwd_wdata = wb_wdata;
`endif

endmodule
`default_nettype wire
